// File: rtl/uart_pkg.sv
// Shared UART framing definitions for the receive and transmit paths.
// Frame: start, 8 data LSB first, even parity, 2 stop bits.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2,
      WAIT_HIGH
   } state_e;

   localparam int DATA_BITS   = 8;
   localparam int STOP_BITS   = 2;
   localparam bit PARITY_EVEN = 1'b1;
   localparam int FRAME_BITS  = 1 + DATA_BITS + 1 + STOP_BITS;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return (^d) ^ ~PARITY_EVEN;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high asynchronous input.
// Both stages reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: mid-bit sampling, even parity, 2 stop bits,
// byte delivery through a valid/ack handshake with sticky overrun.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 DataIn,
   input  logic                 ReadAck,
   output logic [DATA_BITS-1:0] DataOut,
   output logic                 DataValid,
   output logic                 ParityError,
   output logic                 FramingError,
   output logic                 Overrun
);

   localparam int unsigned H  = CLKS_PER_BIT / 2;
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MID = CW'(H - 1);
   localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    IDX_END = 3'(DATA_BITS - 1);

   logic rx;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 serr_q, serr_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 dv_q, dv_d;
   logic                 pe_q, pe_d;
   logic                 fe_q, fe_d;
   logic                 ov_q, ov_d;
   logic                 wrap;
   logic                 done;

   uart_rx_sync u_sync (
      .clk   (Clock),
      .rst_n (Reset),
      .d     (DataIn),
      .q     (rx)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      serr_d  = serr_q;
      dout_d  = dout_q;
      dv_d    = dv_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      ov_d    = ov_q;
      done    = 1'b0;
      wrap    = (cnt_q == CNT_END);

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_MID) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
            if (wrap) begin
               shreg_d = {rx, shreg_q[DATA_BITS-1:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == IDX_END) state_d = PARITY;
            end
         end
         PARITY: begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
            if (wrap) begin
               par_d   = rx;
               state_d = STOP1;
            end
         end
         STOP1: begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
            if (wrap) begin
               serr_d  = ~rx;
               state_d = STOP2;
            end
         end
         STOP2: begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
            if (wrap) begin
               done    = 1'b1;
               dout_d  = shreg_q;
               pe_d    = parity_of(shreg_q) != par_q;
               fe_d    = serr_q | ~rx;
               state_d = rx ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rx) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      // an ack on the completion edge consumes the old byte, so no overrun
      if (done) begin
         dv_d = 1'b1;
         if (dv_q) ov_d = ~ReadAck;
      end else if (ReadAck && dv_q) begin
         dv_d = 1'b0;
         ov_d = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         serr_q  <= 1'b0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         serr_q  <= serr_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   assign DataOut      = dout_q;
   assign DataValid    = dv_q;
   assign ParityError  = pe_q;
   assign FramingError = fe_q;
   assign Overrun      = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames plus random traffic,
// checked each cycle against a frame-level event model.
module tb_uart_receiver;

   localparam int CPB = 16;
   localparam int H   = CPB / 2;
   localparam int LAT = 2 + H + 11 * CPB;

   logic       Clock;
   logic       Reset;
   logic       DataIn;
   logic       ReadAck;
   logic [7:0] DataOut;
   logic       DataValid;
   logic       ParityError;
   logic       FramingError;
   logic       Overrun;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .DataIn       (DataIn),
      .ReadAck      (ReadAck),
      .DataOut      (DataOut),
      .DataValid    (DataValid),
      .ParityError  (ParityError),
      .FramingError (FramingError),
      .Overrun      (Overrun)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      int         at;
      logic [7:0] d;
      logic       pb;
      logic       fe;
   } ev_t;

   ev_t  pend[$];
   ev_t  ev;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   shown = 0;
   int   last_done = 0;
   int   rises = 0;
   int   rise_edge = 0;
   logic dv_prev = 1'b0;
   logic rand_on = 1'b0;

   logic [7:0] m_dout = 8'h00;
   logic       m_dv = 1'b0;
   logic       m_pe = 1'b0;
   logic       m_fe = 1'b0;
   logic       m_ov = 1'b0;
   logic       ack;

   // Model: a byte lands LAT edges after its start bit; ack consumes it.
   always @(posedge Clock) begin
      cyc = cyc + 1;
      if (!Reset) begin
         m_dout = 8'h00;
         m_dv = 1'b0;
         m_pe = 1'b0;
         m_fe = 1'b0;
         m_ov = 1'b0;
         pend.delete();
      end else begin
         ack = ReadAck;
         if (pend.size() > 0 && pend[0].at == cyc) begin
            ev = pend.pop_front();
            if (m_dv) m_ov = !ack;
            m_dv = 1'b1;
            m_dout = ev.d;
            m_pe = ((^ev.d) != ev.pb);
            m_fe = ev.fe;
         end else if (ack && m_dv) begin
            m_dv = 1'b0;
            m_ov = 1'b0;
         end
      end
   end

   always @(negedge Clock) begin
      if (Reset) begin
         checks = checks + 1;
         if ({DataValid, Overrun, ParityError, FramingError, DataOut} !==
             {m_dv, m_ov, m_pe, m_fe, m_dout}) begin
            failures = failures + 1;
            if (shown < 10)
               $display("FAIL cycle %0d model: got dv=%b ov=%b pe=%b fe=%b d=%h expected dv=%b ov=%b pe=%b fe=%b d=%h",
                        cyc, DataValid, Overrun, ParityError, FramingError, DataOut,
                        m_dv, m_ov, m_pe, m_fe, m_dout);
            shown = shown + 1;
         end
      end
      if (DataValid && !dv_prev) begin
         rises = rises + 1;
         rise_edge = cyc;
      end
      dv_prev = DataValid;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_bits(input logic b, input int n);
      DataIn = b;
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_bad,
                             input logic s1, input logic s2, input int nbits);
      logic [11:0] f;
      ev_t e;
      f = {s2, s1, (^d) ^ par_bad, d, 1'b0};
      last_done = cyc + 1 + LAT;
      if (nbits == 12) begin
         e.at = last_done;
         e.d  = d;
         e.pb = f[9];
         e.fe = !(s1 && s2);
         pend.push_back(e);
      end
      for (int i = 0; i < nbits; i++) drive_bits(f[i], CPB);
   endtask

   task automatic ack_once();
      ReadAck = 1'b1;
      @(posedge Clock);
      #1;
      ReadAck = 1'b0;
   endtask

   initial begin
      int r0;
      Reset = 1'b0;
      DataIn = 1'b1;
      ReadAck = 1'b0;
      #3;
      chk("reset_outs", 32'({DataValid, Overrun, ParityError, FramingError, DataOut}), 32'h0);
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b1;
      drive_bits(1'b1, 2 * CPB);

      // 0xA5 clean, latency pinned
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 12);
      drive_bits(1'b1, CPB);
      chk("a5_rise_edge", 32'(rise_edge), 32'(last_done));
      chk("a5_data", 32'(DataOut), 32'hA5);
      chk("a5_flags", 32'({DataValid, ParityError, FramingError, Overrun}), 32'b1000);
      ack_once();
      chk("a5_ack_dv", 32'(DataValid), 32'h0);

      // 0x7E with stop errors then a 40-bit break
      r0 = rises;
      send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 12);
      drive_bits(1'b0, 39 * CPB);
      chk("brk_rises", 32'(rises - r0), 32'd1);
      chk("brk_fe", 32'(FramingError), 32'h1);
      chk("brk_data", 32'(DataOut), 32'h7E);
      drive_bits(1'b1, 2 * CPB);
      ack_once();
      send_frame(8'h42, 1'b0, 1'b1, 1'b1, 12);
      drive_bits(1'b1, CPB);
      chk("x42_data", 32'(DataOut), 32'h42);
      chk("x42_flags", 32'({DataValid, ParityError, FramingError, Overrun}), 32'b1000);
      ack_once();

      // short glitch on idle line
      r0 = rises;
      drive_bits(1'b0, 5);
      drive_bits(1'b1, 3 * CPB);
      chk("glitch_no_dv", 32'(rises - r0), 32'd0);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 12);
      drive_bits(1'b1, CPB);
      chk("glitch_3c", 32'(DataOut), 32'h3C);
      ack_once();

      // back-to-back without ack
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 12);
      send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 12);
      drive_bits(1'b1, CPB);
      chk("ovr_data", 32'(DataOut), 32'hC3);
      chk("ovr_flag", 32'({DataValid, Overrun}), 32'b11);
      ack_once();
      chk("ovr_ack", 32'({DataValid, Overrun}), 32'b00);

      // back-to-back with ack on the completion edge
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 12);
      fork
         send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 12);
         begin
            int e;
            @(posedge Clock);
            #2;
            e = last_done;
            while (cyc < e - 1) begin
               @(posedge Clock);
               #1;
            end
            ReadAck = 1'b1;
            @(posedge Clock);
            #1;
            ReadAck = 1'b0;
         end
      join
      drive_bits(1'b1, CPB);
      chk("ack_edge_data", 32'(DataOut), 32'hC3);
      chk("ack_edge_flag", 32'({DataValid, Overrun}), 32'b10);
      ack_once();

      // random traffic with random acks
      rand_on = 1'b1;
      fork
         begin
            for (int n = 0; n < 25; n++) begin
               logic [7:0] d;
               logic pb, s1, s2;
               d  = 8'($urandom_range(0, 255));
               pb = ($urandom_range(0, 4) == 0);
               s1 = ($urandom_range(0, 5) != 0);
               s2 = ($urandom_range(0, 5) != 0);
               send_frame(d, pb, s1, s2, 12);
               drive_bits(1'b1, $urandom_range(s2 ? 0 : 2, 40));
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge Clock);
               #1;
               ReadAck = ($urandom_range(0, 19) == 0);
            end
            ReadAck = 1'b0;
         end
      join
      drive_bits(1'b1, CPB);
      ack_once();

      // 0x01 with wrong parity bit
      send_frame(8'h01, 1'b1, 1'b1, 1'b1, 12);
      drive_bits(1'b1, CPB);
      chk("p01_data", 32'(DataOut), 32'h01);
      chk("p01_flags", 32'({DataValid, ParityError, FramingError}), 32'b110);

      // reset during data bit 4 of 0x55
      send_frame(8'h55, 1'b0, 1'b1, 1'b1, 5);
      DataIn = 1'b1;
      repeat (5) @(posedge Clock);
      #3;
      chk("pre_rst_dv", 32'(DataValid), 32'h1);
      Reset = 1'b0;
      #1;
      chk("rst_outs", 32'({DataValid, Overrun, ParityError, FramingError, DataOut}), 32'h0);
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b1;
      drive_bits(1'b1, 2 * CPB);
      send_frame(8'h55, 1'b0, 1'b1, 1'b1, 12);
      drive_bits(1'b1, CPB);
      chk("x55_data", 32'(DataOut), 32'h55);
      chk("x55_flags", 32'({DataValid, ParityError, FramingError, Overrun}), 32'b1000);
      chk("pend_empty", 32'(pend.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
